// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential, BGT, J, JR) and the
// IF/ID pipeline register with stall hold, flush bubbles and a saturating redirect counter.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_flush,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc_plus4_id,
  output logic             valid_id,
  output logic [CNT_W-1:0] redirect_count
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        redirect;
  logic [31:0] redirect_tgt;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4_q + {branch_offset[29:0], 2'b00};
  assign j_tgt    = {pc_plus4_q[31:28], jump_index, 2'b00};

  // Redirects only count when ID holds a real instruction; bubbles never redirect.
  assign redirect = valid_q & (jr | jump | branch_taken);

  always_comb begin
    redirect_tgt = br_tgt;
    if (jr) begin
      redirect_tgt = jr_target;
    end else if (jump) begin
      redirect_tgt = j_tgt;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    // Stall overrides flush and redirects: ID operands are not yet valid.
    if (!stall) begin
      pc_d       = redirect ? redirect_tgt : pc_plus4;
      pc_plus4_d = pc_plus4;
      if (if_flush || redirect) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_data;
        valid_d = 1'b1;
      end
      if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign instr_id       = instr_q;
  assign pc_plus4_id    = pc_plus4_q;
  assign valid_id       = valid_q;
  assign redirect_count = cnt_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Directly upstream of, and feeding, the ID-stage decoder and control unit.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC: sequential, BGT branch, J jump, or JR register jump. Redirect decisions come from the ID stage.
- Owns the IF/ID pipeline register, including stall hold and IF_Flush bubble insertion. Keeps a saturating redirect counter for performance debug.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, instruction word injected into IF/ID on a flush (sll $0,$0,0).
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  load-use hazard from the hazard unit; holds the PC and IF/ID.
- if_flush  input  1  IF_Flush from the control unit; squashes the fetched instruction.
- jump  input  1  Jump from the control unit (J opcode in ID).
- jump_index  input  26  instr_id[25:0], the J target field.
- branch_taken  input  1  Branch AND bgt_id, resolved in ID.
- branch_offset  input  32  sign-extended instr_id[15:0].
- jr  input  1  JR decoded in ID (R-type, funct 6'b001000).
- jr_target  input  32  forwarded rs value for JR.
- imem_addr  output  32  instruction-memory address; equals the PC register.
- imem_data  input  32  instruction word, combinational read of imem_addr.
- instr_id  output  32  IF/ID instruction.
- pc_plus4_id  output  32  IF/ID PC+4.
- valid_id  output  1  IF/ID holds a real (non-bubble) instruction.
- redirect_count  output  CNT_W  number of taken redirects since reset, saturating.

Behaviour:
- Reset: the synchronous, active-high reset has priority over everything. On reset, all state loads as follows:
  - PC <= RESET_PC
  - instr_id <= NOP_INSTR
  - pc_plus4_id <= 0
  - valid_id <= 0
  - redirect_count <= 0
- Reset asserted mid-stream discards in-flight state; the first fetch after deassertion is from RESET_PC.
- Combinational signals:
  - pc_plus4 = PC + 32'd4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - imem_addr = PC.
- Redirect targets, all computed from the ID-stage values:
  - br_tgt = pc_plus4_id + (branch_offset << 2), modulo 2^32.
  - j_tgt = {pc_plus4_id[31:28], jump_index, 2'b00}.
  - jr_tgt = jr_target. Bits [1:0] are passed unmodified; misalignment is not checked.
- A redirect request is qualified only when valid_id = 1. jump, branch_taken and jr are ignored while valid_id = 0.
- Next-PC priority, highest first:
  1. stall: PC holds.
  2. qualified jr: PC <= jr_tgt.
  3. qualified jump: PC <= j_tgt.
  4. qualified branch_taken: PC <= br_tgt.
  5. Otherwise: PC <= pc_plus4.
- IF/ID register update, highest priority first:
  1. stall = 1: hold all of instr_id, pc_plus4_id and valid_id. stall overrides if_flush and redirects, because ID operands are not yet valid.
  2. if_flush = 1, or any qualified redirect: instr_id <= NOP_INSTR, pc_plus4_id <= pc_plus4, valid_id <= 0.
  3. Otherwise: instr_id <= imem_data, pc_plus4_id <= pc_plus4, valid_id <= 1.
- Redirect latency: a redirect seen in ID in cycle N makes the target PC visible on imem_addr in cycle N+1. The target instruction reaches ID in cycle N+2, leaving exactly one bubble.
- A not-taken BGT costs no bubble; if_flush is low in that case.
- redirect_count increments by 1 on each cycle where stall = 0 and a qualified redirect occurs. It saturates at all-ones and does not wrap.
- Simultaneous requests: jr, jump and branch_taken active together are legal. The priority order above decides the target, and the counter increments by 1 only.
- Back-to-back redirects cannot occur, because the bubble after a redirect has valid_id = 0.

Test Plan:
- Reset, then 4 free-running cycles with imem returning the address as data:
  - imem_addr sequence: 0, 4, 8, 12.
  - instr_id lags by one cycle.
  - valid_id = 0 in the first cycle after reset, then 1.
- Taken BGT: pc_plus4_id = 0x20, branch_offset = 0xFFFFFFFC, branch_taken = 1, if_flush = 1:
  - next imem_addr = 0x10.
  - One NOP with valid_id = 0 in ID.
  - redirect_count = 1.
- J with pc_plus4_id = 0x40000008 and jump_index = 0x0000100:
  - imem_addr = 0x40000400 next cycle.
  - jump and jr together with jr_target = 0x80: imem_addr = 0x80 (jr wins).
- stall = 1 held for 2 cycles while branch_taken = 1 and if_flush = 1:
  - PC, instr_id and valid_id are unchanged.
  - redirect_count is unchanged.
  - The redirect applies on the first cycle after stall drops.
- PC = 0xFFFFFFFC, sequential: next imem_addr = 0 and pc_plus4_id = 0.
- With CNT_W = 2, force 5 redirects: redirect_count = 3 (saturated).
- Assert reset mid-redirect: PC = RESET_PC and valid_id = 0 on the next cycle.
